fifo_stream_bridge: RTL and testbench
=====================================

# fifo_stream_bridge

Read-side consumer for `SyncFIFO`. It pops 32-bit words through the FIFO's `re_i`/`empty_o`/`data_o` port and presents them downstream as a valid/ready stream. A 2-entry prefetch buffer sustains one word per cycle despite the FIFO's one-cycle read latency. It also marks burst boundaries with `m_last_o`.

## Interface
- `DATA_W`, default 32: word width; matches FIFO `data_o`.
- `BURST_LEN`, default 4: beats per burst; `m_last_o` is asserted on every BURST_LEN-th beat. Legal range 1..256.
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `empty_i`, input, 1: FIFO `empty_o`.
- `data_i`, input, DATA_W: FIFO `data_o`; valid the cycle after a read is issued.
- `re_o`, output, 1: FIFO `re_i`; pop request.
- `m_valid_o`, output, 1: downstream word valid.
- `m_ready_i`, input, 1: downstream accept.
- `m_data_o`, output, DATA_W: downstream word; the buffer head.
- `m_last_o`, output, 1: current beat closes a burst.
- `beat_cnt_o`, output, 8: beats accepted in the current burst, range 0..BURST_LEN-1.

## Operation
- **State:**
  - `cnt_q` (0..2): buffered words.
  - `pend_q`: read issued last cycle.
  - 2-entry circular buffer with `wr_ptr_q`/`rd_ptr_q`.
  - `beat_q`.
- **Pop condition:** `pop = m_valid_o & m_ready_i`.
- **Read issue:** `re_o = rst_n & ~empty_i & (cnt_q + pend_q - pop < 2)`.
  - Combinational on `m_ready_i`, so credit freed by a same-cycle pop is reused immediately.
  - No read is ever issued without a guaranteed buffer slot.
- **Capture:** when `pend_q` is 1, `data_i` is written at `wr_ptr_q` this cycle and `wr_ptr_q` toggles.
- **Counting:** `cnt_q` next = `cnt_q + pend_q - pop`. Simultaneous capture and pop leaves `cnt_q` unchanged.
- **Output:** `m_valid_o = (cnt_q != 0)`; `m_data_o` = entry at `rd_ptr_q`; `rd_ptr_q` toggles on pop.
- **Burst tracking:**
  - `m_last_o = m_valid_o & (beat_q == BURST_LEN-1)`.
  - On pop, `beat_q` increments and wraps to 0 after the last beat.
  - BURST_LEN=1 makes every beat last.
- **Stall behaviour:** an empty FIFO mid-burst only stalls; `beat_q` holds and the burst resumes when words arrive.
- **Ordering:** words leave in FIFO order; none are dropped or duplicated.
- **Protocol:** downstream may deassert `m_ready_i` at any time. The bridge keeps `m_valid_o` and `m_data_o` stable until the word is accepted.

## Timing
- **Reset values:** while `rst_n=0` at a clock edge, `cnt_q`, `pend_q`, pointers and `beat_q` clear. `re_o`, `m_valid_o` and `m_last_o` are 0, `beat_cnt_o` is 0, and `m_data_o` is 0 (buffer cleared).
- **Read during reset:** `re_o` is forced 0 during reset.
- **Reset mid-operation:** buffered and in-flight words are discarded; a word already popped from the FIFO is lost by design.
- **Latency:** `empty_i` falls in cycle N, so `re_o` is high in N, data is captured at the end of N+1, and `m_valid_o` is high in N+2.
- **Throughput:** with `m_ready_i` held high and the FIFO non-empty, one beat per cycle from N+2.
- **Backpressure:** with `m_ready_i` low, at most 2 words are prefetched.
  - `re_o` drops once `cnt_q + pend_q = 2`.
  - After `m_ready_i` rises, the first pop is in the same cycle and `re_o` reasserts in that cycle.

## Configuration
- Macro `FIFO_BRIDGE_SUM_EN`.
- **Defined:** adds outputs `sum_o` [DATA_W] and `sum_valid_o` [1].
  - `sum_o` is the running sum, modulo 2^DATA_W, of beats accepted in the current burst, including the current one.
  - On the pop of a last beat, `sum_valid_o` pulses for one cycle.
  - In that pulse cycle `sum_o` shows the full-burst sum; the accumulator clears at the same edge.
  - Reset value of both outputs is 0.
- **Undefined:** the ports and the accumulator are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n=0` 3 cycles with `empty_i=0` -> `re_o=0`, `m_valid_o=0`, `beat_cnt_o=0` throughout.
- **Single word:** FIFO holds 0xDEADBEEF, `m_ready_i=1` -> `re_o` 1 cycle, `m_valid_o` 2 cycles after `empty_i` falls, `m_data_o=0xDEADBEEF`, `m_last_o=0`.
- **Burst framing:** 8 words 1..8, ready high -> 8 consecutive beats, `m_last_o` on values 4 and 8, `beat_cnt_o` sequence 0,1,2,3,0,1,2,3.
- **Backpressure:** 6 words with `m_ready_i=0` -> exactly 2 reads issued, `re_o` then 0. Raise ready -> remaining 4 words delivered in order 1..6 with no gap after the first beat.
- **Starvation mid-burst:** 2 words, FIFO empty for 5 cycles, then 2 words -> `m_last_o` on the 4th beat only; `beat_q` holds during the gap.
- **Reset mid-stream:** assert reset while 2 words are buffered -> outputs clear next edge; after release the next FIFO word starts a new burst at `beat_cnt_o=0`.
- **Sum (`FIFO_BRIDGE_SUM_EN` defined):** words 0xFFFFFFFF,1,2,3 -> `sum_valid_o` on 4th pop with `sum_o=0x00000005` (wrapped); the next burst starts from 0.

Source files
------------

// File: rtl/fifo_stream_bridge.sv
// fifo_stream_bridge: turns the read side of a SyncFIFO (re/empty/data with
// one-cycle read latency) into a valid/ready stream. A 2-entry prefetch buffer
// keeps one beat per cycle flowing, and m_last_o marks every BURST_LEN-th beat.
// Optional macro FIFO_BRIDGE_SUM_EN adds a per-burst running sum
// (sum_o / sum_valid_o).
module fifo_stream_bridge #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              re_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic [7:0]        beat_cnt_o
`ifdef FIFO_BRIDGE_SUM_EN
    ,
    output logic [DATA_W-1:0] sum_o,
    output logic              sum_valid_o
`endif
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    logic [1:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic [7:0]        beat_q, beat_d;
    logic              pop;
    logic [2:0]        occ;

`ifdef FIFO_BRIDGE_SUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    // Stream outputs and read issue; re_o sees this cycle's pop so a freed slot is refilled at once.
    always_comb begin
        m_valid_o  = (cnt_q != 2'd0);
        m_data_o   = buf_q[rd_ptr_q];
        pop        = m_valid_o & m_ready_i;
        // Occupancy after this edge, counting the word already in flight.
        occ        = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
        re_o       = rst_n & ~empty_i & (occ < 3'd2);
        m_last_o   = m_valid_o & (beat_q == LAST_BEAT);
        beat_cnt_o = beat_q;
    end

    // Next-state: capture the in-flight word, advance pointers, track burst position.
    always_comb begin
        cnt_d    = occ[1:0];
        pend_d   = re_o;
        wr_ptr_d = wr_ptr_q ^ pend_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        buf_d    = buf_q;
        if (pend_q) begin
            buf_d[wr_ptr_q] = data_i;
        end
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
        end
    end

`ifdef FIFO_BRIDGE_SUM_EN
    // Running burst sum includes the beat being accepted; clears behind the last beat.
    always_comb begin
        sum_o       = acc_q + (pop ? m_data_o : '0);
        sum_valid_o = pop & m_last_o;
        acc_d       = sum_valid_o ? '0 : sum_o;
    end
`endif

    // State registers with synchronous active-low reset; buffer contents cleared too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            pend_q   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            beat_q   <= 8'd0;
`ifdef FIFO_BRIDGE_SUM_EN
            acc_q    <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            beat_q   <= beat_d;
`ifdef FIFO_BRIDGE_SUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_stream_bridge.sv
// Bench for fifo_stream_bridge: a behavioural SyncFIFO feeds the bridge and a
// scoreboard queue holds every word pushed, checked in order as beats are accepted.
module tb_fifo_stream_bridge;

    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;

    logic              clk;
    logic              rst_n;
    logic              empty_i;
    logic [DATA_W-1:0] data_i;
    logic              re_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic [7:0]        beat_cnt_o;
`ifdef FIFO_BRIDGE_SUM_EN
    logic [DATA_W-1:0] sum_o;
    logic              sum_valid_o;
`endif

    fifo_stream_bridge #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .empty_i    (empty_i),
        .data_i     (data_i),
        .re_o       (re_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o),
        .beat_cnt_o (beat_cnt_o)
`ifdef FIFO_BRIDGE_SUM_EN
        ,
        .sum_o      (sum_o),
        .sum_valid_o(sum_valid_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SyncFIFO model: data appears the cycle after re.
    logic [DATA_W-1:0] mem [0:255];
    int wcnt = 0;
    int rcnt = 0;
    assign empty_i = (wcnt == rcnt);
    initial data_i = '0;
    always @(posedge clk) begin
        if (re_o) begin
            data_i <= mem[rcnt % 256];
            rcnt   <= rcnt + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] sb_q[$];
    int exp_beat = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int first_pop = 0;
    int last_pop = 0;
    int re_cnt = 0;
    int sumv_cnt = 0;
    logic [DATA_W-1:0] exp_sum = '0;

    task automatic push_word(input logic [DATA_W-1:0] w);
        mem[wcnt % 256] = w;
        wcnt++;
        sb_q.push_back(w);
    endtask

    // One clock: settle, score any accepted beat, move to the next negedge.
    task automatic tick();
        logic [DATA_W-1:0] exp;
        logic exp_last;
        #1;
        if (re_o) re_cnt++;
        if (m_valid_o && m_ready_i) begin
            pop_cnt++;
            if (pop_cnt == 1) first_pop = cyc;
            last_pop = cyc;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %h, expected no beat", m_data_o);
            end else begin
                exp      = sb_q.pop_front();
                exp_last = (exp_beat == BURST_LEN - 1);
                if (m_data_o !== exp) begin
                    errors++;
                    $display("FAIL sb_data: got %h, expected %h", m_data_o, exp);
                end
                checks++;
                if (m_last_o !== exp_last) begin
                    errors++;
                    $display("FAIL sb_last: data %h got %b, expected %b", exp, m_last_o, exp_last);
                end
                checks++;
                if (beat_cnt_o !== 8'(exp_beat)) begin
                    errors++;
                    $display("FAIL sb_beat: data %h got %0d, expected %0d", exp, beat_cnt_o, exp_beat);
                end
`ifdef FIFO_BRIDGE_SUM_EN
                exp_sum = exp_sum + exp;
                checks++;
                if (sum_valid_o !== exp_last) begin
                    errors++;
                    $display("FAIL sum_valid: got %b, expected %b", sum_valid_o, exp_last);
                end
                if (exp_last) begin
                    sumv_cnt++;
                    checks++;
                    if (sum_o !== exp_sum) begin
                        errors++;
                        $display("FAIL sum_value: got %h, expected %h", sum_o, exp_sum);
                    end
                    exp_sum = '0;
                end
`endif
                exp_beat = (exp_beat + 1) % BURST_LEN;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && sb_q.size() != 0; i++) tick();
        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words left, expected 0", sb_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        m_ready_i = 1'b0;
        sb_q.delete();
        exp_beat  = 0;
        exp_sum   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        push_word(32'h0000_0011);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (re_o !== 1'b0 || m_valid_o !== 1'b0 || beat_cnt_o !== 8'd0 ||
                m_last_o !== 1'b0 || m_data_o !== '0) begin
                errors++;
                $display("FAIL reset_outputs: re=%b valid=%b beat=%0d last=%b data=%h, expected all 0",
                         re_o, m_valid_o, beat_cnt_o, m_last_o, m_data_o);
            end
            tick();
        end
        rst_n     = 1'b1;
        m_ready_i = 1'b1;
        drain(10);
    endtask

    task automatic test_single();
        do_reset();
        m_ready_i = 1'b1;
        push_word(32'hDEAD_BEEF);
        #1;
        checks++;
        if (re_o !== 1'b1 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_n: re=%b valid=%b, expected re=1 valid=0", re_o, m_valid_o);
        end
        tick();
        #1;
        checks++;
        if (re_o !== 1'b0 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_n1: re=%b valid=%b, expected 0 0", re_o, m_valid_o);
        end
        tick();
        #1;
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'hDEAD_BEEF || m_last_o !== 1'b0) begin
            errors++;
            $display("FAIL single_n2: valid=%b data=%h last=%b, expected 1 deadbeef 0",
                     m_valid_o, m_data_o, m_last_o);
        end
        tick();
        #1;
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_after: valid=%b, expected 0", m_valid_o);
        end
        drain(4);
    endtask

    task automatic test_burst();
        do_reset();
        m_ready_i = 1'b1;
        pop_cnt   = 0;
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        drain(20);
        checks++;
        if (pop_cnt != 8 || last_pop - first_pop != 7) begin
            errors++;
            $display("FAIL burst_rate: pops=%0d span=%0d, expected 8 and 7", pop_cnt, last_pop - first_pop);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready_i = 1'b0;
        re_cnt    = 0;
        for (int i = 1; i <= 6; i++) push_word(32'(i));
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (re_cnt != 2) begin
            errors++;
            $display("FAIL bp_reads: got %0d reads, expected 2", re_cnt);
        end
        #1;
        checks++;
        if (re_o !== 1'b0 || m_valid_o !== 1'b1 || m_data_o !== 32'd1) begin
            errors++;
            $display("FAIL bp_hold: re=%b valid=%b data=%h, expected 0 1 00000001", re_o, m_valid_o, m_data_o);
        end
        m_ready_i = 1'b1;
        pop_cnt   = 0;
        #1;
        checks++;
        if (re_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_reissue: re=%b, expected 1", re_o);
        end
        drain(20);
        checks++;
        if (pop_cnt != 6 || last_pop - first_pop != 5) begin
            errors++;
            $display("FAIL bp_rate: pops=%0d span=%0d, expected 6 and 5", pop_cnt, last_pop - first_pop);
        end
    endtask

    task automatic test_starve();
        do_reset();
        m_ready_i = 1'b1;
        push_word(32'h10);
        push_word(32'h11);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (beat_cnt_o !== 8'd2 || m_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL starve_hold: beat=%0d valid=%b, expected 2 0", beat_cnt_o, m_valid_o);
            end
            tick();
        end
        push_word(32'h12);
        push_word(32'h13);
        drain(10);
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready_i = 1'b1;
        push_word(32'h20);
        for (int i = 0; i < 3; i++) tick();
        m_ready_i = 1'b0;
        push_word(32'h21);
        push_word(32'h22);
        for (int i = 0; i < 4; i++) tick();
        #1;
        checks++;
        if (m_valid_o !== 1'b1 || beat_cnt_o !== 8'd1 || m_data_o !== 32'h21) begin
            errors++;
            $display("FAIL mid_pre: valid=%b beat=%0d data=%h, expected 1 1 00000021",
                     m_valid_o, beat_cnt_o, m_data_o);
        end
        rst_n = 1'b0;
        sb_q.delete();
        exp_beat = 0;
        exp_sum  = '0;
        tick();
        #1;
        checks++;
        if (m_valid_o !== 1'b0 || m_data_o !== '0 || beat_cnt_o !== 8'd0 ||
            re_o !== 1'b0 || m_last_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear: valid=%b data=%h beat=%0d re=%b last=%b, expected all 0",
                     m_valid_o, m_data_o, beat_cnt_o, re_o, m_last_o);
        end
        rst_n     = 1'b1;
        m_ready_i = 1'b1;
        push_word(32'h30);
        drain(10);
    endtask

`ifdef FIFO_BRIDGE_SUM_EN
    task automatic test_sum();
        do_reset();
        m_ready_i = 1'b1;
        sumv_cnt  = 0;
        push_word(32'hFFFF_FFFF);
        push_word(32'd1);
        push_word(32'd2);
        push_word(32'd3);
        push_word(32'd5);
        push_word(32'd6);
        push_word(32'd7);
        push_word(32'd8);
        drain(20);
        checks++;
        if (sumv_cnt != 2) begin
            errors++;
            $display("FAIL sum_pulses: got %0d, expected 2", sumv_cnt);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        m_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_starve();
        test_reset_mid();
`ifdef FIFO_BRIDGE_SUM_EN
        test_sum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
